biu8085: RTL and testbench
==========================

BIU8085 -- requirements
Module: biu8085

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum consecutive TW states before abort (used only with WAIT_TIMEOUT_EN).
REQ-002 SHALL have port CLK, input, 1: single clock; all state changes on posedge.
REQ-003 SHALL have port RESETn, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port req, input, 1: core transfer request.
REQ-005 SHALL have port req_ready, output, 1: request accepted this posedge when req=1.
REQ-006 SHALL have port wr, input, 1: 1=write, 0=read.
REQ-007 SHALL have port io, input, 1: 1=I/O space, 0=memory.
REQ-008 SHALL have port addr, input, 16: transfer address.
REQ-009 SHALL have port wdata, input, 8: write data.
REQ-010 SHALL have port rdata, output, 8: read data, valid when done=1.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1: one-cycle timeout pulse, coincident with done.
REQ-013 SHALL have port AD, inout, 8: multiplexed address low byte / data bus.
REQ-014 SHALL have port ADD, output, 16: latched full address, held for the entire bus cycle.
REQ-015 SHALL have ports ALE, RDn, WRn, IO_Mn, output, 1 each: 8085-style bus strobes.
REQ-016 SHALL have port READY, input, 1: responder ready; low inserts wait states.

Function
REQ-017 SHALL implement states IDLE, T1, T2, TW, T3, registered from posedge CLK.
REQ-018 req_ready SHALL be 1 in IDLE and T3, else 0; accepted request latches wr, io, addr, wdata and enters T1.
REQ-019 T1: ALE=1; AD driven with addr[7:0]; ADD=addr; IO_Mn=io; RDn=WRn=1.
REQ-020 T2: ALE=0; read: RDn=0, AD high-Z; write: WRn=0, AD driven with wdata.
REQ-021 End of T2 and each TW: READY=0 -> TW; READY=1 -> T3.
REQ-022 TW: strobes and AD identical to T2.
REQ-023 T3: strobes remain asserted; at the closing posedge rdata SHALL capture AD (reads only; unchanged on writes), done SHALL pulse, RDn/WRn deassert.
REQ-024 T3 with accepted req -> T1 (3-clock back-to-back transfer); otherwise -> IDLE.
REQ-025 Read latency SHALL be 3 clocks from acceptance to done with READY=1, plus 1 clock per wait state.
REQ-026 RDn and WRn SHALL never both be 0; AD SHALL be high-Z whenever RDn=0 and in IDLE.
REQ-027 ADD and IO_Mn SHALL hold their values from T1 until the next accepted request.
REQ-028 req while in T1, T2 or TW SHALL be ignored; the core holds req until req_ready.

Reset
REQ-029 RESETn=0 at posedge SHALL force IDLE, ALE=0, RDn=1, WRn=1, IO_Mn=0, ADD=0, AD high-Z, rdata=0, done=0, err=0, wait counter=0.
REQ-030 Reset mid-cycle SHALL abort without a done pulse; strobes deassert at that posedge.

Configuration
REQ-031 With WAIT_TIMEOUT_EN defined: a TW counter counts consecutive wait states; when it reaches TIMEOUT_CYCLES, the next state SHALL be T3 regardless of READY, with done=1 and err=1 at the end of T3 and rdata unchanged.
REQ-032 Without WAIT_TIMEOUT_EN: no counter; TW persists indefinitely while READY=0; err is tied to 0.

Verification
REQ-033 Read addr=16'h0100, READY=1, responder returns 8'h3E -> T1/T2/T3 sequence; ALE high one clock with AD=8'h00; ADD=16'h0100; done after 3 clocks; rdata=8'h3E.
REQ-034 Write io=1 addr=16'h0042 wdata=8'hA5 -> IO_Mn=1, WRn low for T2 and T3, AD=8'hA5; RDn stays 1.
REQ-035 Read with READY low for 2 clocks -> 2 TW states; done after 5 clocks; RDn low for 4 clocks.
REQ-036 req held high for two reads -> second T1 immediately follows first T3; done pulses 3 clocks apart.
REQ-037 RESETn=0 during TW -> next cycle IDLE, RDn=1, AD high-Z, no done.
REQ-038 WAIT_TIMEOUT_EN, TIMEOUT_CYCLES=16, READY stuck low -> exactly 16 TW, then T3, done=1 and err=1 together; without the macro, still in TW after 100 clocks.

Source files
------------

// File: rtl/biu8085_if.sv
// Core-side request/response bundle of the 8085 bus interface unit.
// The core is the master and the BIU is the slave.
interface biu8085_if;
    logic        req;
    logic        req_ready;
    logic        wr;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        done;
    logic        err;

    modport master (output req, wr, io, addr, wdata,
                    input  req_ready, rdata, done, err);
    modport slave  (input  req, wr, io, addr, wdata,
                    output req_ready, rdata, done, err);
endinterface

// File: rtl/biu8085.sv
// 8085-style multiplexed bus interface unit: T1/T2/TW/T3 cycle sequencer with back-to-back issue.
// Optional wait-state timeout is built in when the macro WAIT_TIMEOUT_EN is defined.
module biu8085 #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESETn,
    biu8085_if.slave    core,
    inout  wire  [7:0]  AD,
    output logic [15:0] ADD,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        IO_Mn,
    input  logic        READY
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_wr;
    logic        r_io;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        r_done;
    logic        r_err;
    logic        w_accept;
    logic        w_strobe;
    logic        w_timeout;
    logic        w_timed_out;
    logic        w_ad_oe;
    logic [7:0]  w_ad_out;

    assign core.req_ready = (r_state == S_IDLE) || (r_state == S_T3);
    assign w_accept       = core.req && core.req_ready;
    assign w_strobe       = (r_state == S_T2) || (r_state == S_TW) || (r_state == S_T3);

`ifdef WAIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_timed_out;

    // Counts the TW state currently being spent; abort when it completes the last allowed one.
    assign w_cnt_inc   = r_wait_cnt + CW'(1);
    assign w_timeout   = (r_state == S_TW) && (w_cnt_inc == CW'(TIMEOUT_CYCLES));
    assign w_timed_out = r_timed_out;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_wait_cnt  <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_wait_cnt <= (w_state_next == S_TW && r_state == S_TW) ? w_cnt_inc : '0;
            if (w_timeout)
                r_timed_out <= 1'b1;
            else if (r_state == S_T3)
                r_timed_out <= 1'b0;
        end
    end
`else
    // The timeout limit has no effect in this build; this expression is constant 0.
    assign w_timeout   = 1'b0;
    assign w_timed_out = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_next = S_T1;
            S_T1:       w_state_next = S_T2;
            S_T2, S_TW: w_state_next = (READY || w_timeout) ? S_T3 : S_TW;
            S_T3:       w_state_next = w_accept ? S_T1 : S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_io    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == S_T3);
            r_err   <= (r_state == S_T3) && w_timed_out;
            if (w_accept) begin
                r_wr    <= core.wr;
                r_io    <= core.io;
                r_addr  <= core.addr;
                r_wdata <= core.wdata;
            end
            // Responder data is sampled at the edge that closes T3, while RDn is still low.
            if (r_state == S_T3 && !r_wr && !w_timed_out)
                r_rdata <= AD;
        end
    end

    assign ALE   = (r_state == S_T1);
    assign RDn   = !(w_strobe && !r_wr);
    assign WRn   = !(w_strobe && r_wr);
    assign ADD   = r_addr;
    assign IO_Mn = r_io;

    assign w_ad_oe  = (r_state == S_T1) || (w_strobe && r_wr);
    assign w_ad_out = (r_state == S_T1) ? r_addr[7:0] : r_wdata;
    assign AD       = w_ad_oe ? w_ad_out : 8'hzz;

    assign core.rdata = r_rdata;
    assign core.done  = r_done;
    assign core.err   = r_err;
endmodule

// File: tb/tb_biu8085.sv
// Directed testbench for biu8085: read, write, wait states, back-to-back, reset abort, timeout.
// AD is a pulled-up net, so an undriven bus reads back as 8'hFF.
module tb_biu8085;
    logic        CLK = 1'b0;
    logic        RESETn;
    logic        READY;
    tri1  [7:0]  AD;
    logic [15:0] ADD;
    logic        ALE, RDn, WRn, IO_Mn;
    logic [7:0]  resp_data;
    logic        resp_mode;
    int          checks = 0;
    int          errors = 0;

    biu8085_if cif();

    biu8085 #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RESETn(RESETn), .core(cif), .AD(AD), .ADD(ADD),
        .ALE(ALE), .RDn(RDn), .WRn(WRn), .IO_Mn(IO_Mn), .READY(READY)
    );

    always #5 CLK = ~CLK;

    // Responder drives the bus only while RDn is low; mode 1 derives data from the high address byte.
    assign AD = !RDn ? (resp_mode ? (ADD[15:8] ^ 8'hC3) : resp_data) : 8'hzz;

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic request(input logic w, input logic i, input logic [15:0] a, input logic [7:0] d);
        cif.req = 1'b1; cif.wr = w; cif.io = i; cif.addr = a; cif.wdata = d;
    endtask

    task automatic test_reset;
        RESETn = 1'b0; READY = 1'b1; resp_data = 8'h00; resp_mode = 1'b0;
        cif.req = 1'b0; cif.wr = 1'b0; cif.io = 1'b0; cif.addr = 16'h0; cif.wdata = 8'h0;
        tick; tick;
        checks++; if ({ALE, RDn, WRn, IO_Mn} !== 4'b0110) begin errors++; $display("FAIL reset_strobes: got %b expected 0110", {ALE, RDn, WRn, IO_Mn}); end
        checks++; if (ADD !== 16'h0000) begin errors++; $display("FAIL reset_add: got %h expected 0000", ADD); end
        checks++; if (AD !== 8'hFF) begin errors++; $display("FAIL reset_ad_hiz: got %h expected FF(pulled)", AD); end
        checks++; if ({cif.done, cif.err, cif.rdata} !== 10'h000) begin errors++; $display("FAIL reset_outputs: got done=%b err=%b rdata=%h expected 0 0 00", cif.done, cif.err, cif.rdata); end
        RESETn = 1'b1;
        tick;
        checks++; if (cif.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", cif.req_ready); end
        $display("reset: done");
    endtask

    task automatic test_read;
        request(1'b0, 1'b0, 16'h0100, 8'h00); resp_data = 8'h3E; READY = 1'b1;
        tick; cif.req = 1'b0;
        checks++; if ({ALE, RDn, WRn, IO_Mn} !== 4'b1110) begin errors++; $display("FAIL rd_t1_strobes: got %b expected 1110", {ALE, RDn, WRn, IO_Mn}); end
        checks++; if (AD !== 8'h00 || ADD !== 16'h0100) begin errors++; $display("FAIL rd_t1_addr: got AD=%h ADD=%h expected 00 0100", AD, ADD); end
        checks++; if (cif.req_ready !== 1'b0) begin errors++; $display("FAIL rd_t1_ready: got %b expected 0", cif.req_ready); end
        tick;
        checks++; if ({ALE, RDn, WRn} !== 3'b001 || AD !== 8'h3E) begin errors++; $display("FAIL rd_t2: got ALE/RDn/WRn=%b AD=%h expected 001 3E", {ALE, RDn, WRn}, AD); end
        tick;
        checks++; if (RDn !== 1'b0 || cif.done !== 1'b0 || cif.req_ready !== 1'b1) begin errors++; $display("FAIL rd_t3: got RDn=%b done=%b rr=%b expected 0 0 1", RDn, cif.done, cif.req_ready); end
        tick;
        checks++; if (cif.done !== 1'b1 || cif.err !== 1'b0 || cif.rdata !== 8'h3E) begin errors++; $display("FAIL rd_done: got done=%b err=%b rdata=%h expected 1 0 3E", cif.done, cif.err, cif.rdata); end
        checks++; if (RDn !== 1'b1 || AD !== 8'hFF || ADD !== 16'h0100) begin errors++; $display("FAIL rd_after: got RDn=%b AD=%h ADD=%h expected 1 FF 0100", RDn, AD, ADD); end
        tick;
        checks++; if (cif.done !== 1'b0) begin errors++; $display("FAIL rd_done_pulse: got %b expected 0", cif.done); end
        $display("read 0100: rdata=%h", cif.rdata);
    endtask

    task automatic test_write;
        request(1'b1, 1'b1, 16'h0042, 8'hA5); READY = 1'b1;
        tick; cif.req = 1'b0;
        checks++; if ({ALE, RDn, WRn, IO_Mn} !== 4'b1111 || AD !== 8'h42) begin errors++; $display("FAIL wr_t1: got strobes=%b AD=%h expected 1111 42", {ALE, RDn, WRn, IO_Mn}, AD); end
        tick;
        checks++; if ({RDn, WRn} !== 2'b10 || AD !== 8'hA5) begin errors++; $display("FAIL wr_t2: got RDn/WRn=%b AD=%h expected 10 A5", {RDn, WRn}, AD); end
        tick;
        checks++; if ({RDn, WRn} !== 2'b10 || AD !== 8'hA5) begin errors++; $display("FAIL wr_t3: got RDn/WRn=%b AD=%h expected 10 A5", {RDn, WRn}, AD); end
        tick;
        checks++; if (cif.done !== 1'b1 || cif.rdata !== 8'h3E) begin errors++; $display("FAIL wr_done: got done=%b rdata=%h expected 1 3E", cif.done, cif.rdata); end
        checks++; if ({RDn, WRn, IO_Mn} !== 3'b111 || ADD !== 16'h0042 || AD !== 8'hFF) begin errors++; $display("FAIL wr_after: got RDn/WRn/IO_Mn=%b ADD=%h AD=%h expected 111 0042 FF", {RDn, WRn, IO_Mn}, ADD, AD); end
        $display("write io 0042: data=A5");
    endtask

    task automatic test_wait_states;
        int done_at = 0;
        int rd_low = 0;
        request(1'b0, 1'b0, 16'h1234, 8'h00); resp_data = 8'h5A; READY = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick;
            if (cyc == 1) cif.req = 1'b0;
            if (cyc == 3) begin
                checks++; if ({ALE, RDn, WRn} !== 3'b001 || AD !== 8'h5A || cif.req_ready !== 1'b0) begin errors++; $display("FAIL tw_strobes: got ALE/RDn/WRn=%b AD=%h rr=%b expected 001 5A 0", {ALE, RDn, WRn}, AD, cif.req_ready); end
            end
            if (cyc == 4) READY = 1'b1;
            if (RDn === 1'b0) rd_low++;
            if (cif.done === 1'b1 && done_at == 0) done_at = cyc;
        end
        checks++; if (done_at - 1 != 5) begin errors++; $display("FAIL wait_latency: got %0d expected 5", done_at - 1); end
        checks++; if (rd_low != 4) begin errors++; $display("FAIL wait_rdn_low: got %0d expected 4", rd_low); end
        checks++; if (cif.rdata !== 8'h5A) begin errors++; $display("FAIL wait_rdata: got %h expected 5A", cif.rdata); end
        $display("read 1234 with 2 wait states: latency=%0d", done_at - 1);
    endtask

    task automatic test_back_to_back;
        int d1 = 0;
        int d2 = 0;
        int n_done = 0;
        resp_mode = 1'b1; READY = 1'b1;
        request(1'b0, 1'b0, 16'h0200, 8'h00);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick;
            if (cyc == 1) cif.addr = 16'h0300;
            if (cyc == 4) begin
                checks++; if (ALE !== 1'b1 || ADD !== 16'h0300) begin errors++; $display("FAIL b2b_second_t1: got ALE=%b ADD=%h expected 1 0300", ALE, ADD); end
                checks++; if (cif.rdata !== 8'hC1) begin errors++; $display("FAIL b2b_rdata1: got %h expected C1", cif.rdata); end
                cif.req = 1'b0;
            end
            if (cif.done === 1'b1) begin
                n_done++;
                if (d1 == 0) d1 = cyc; else if (d2 == 0) d2 = cyc;
            end
        end
        checks++; if (n_done != 2 || d1 != 4 || d2 != 7) begin errors++; $display("FAIL b2b_done: got n=%0d at %0d,%0d expected 2 at 4,7", n_done, d1, d2); end
        checks++; if (cif.rdata !== 8'hC0) begin errors++; $display("FAIL b2b_rdata2: got %h expected C0", cif.rdata); end
        resp_mode = 1'b0;
        $display("back-to-back reads 0200/0300: done at %0d and %0d", d1, d2);
    endtask

    task automatic test_reset_mid;
        request(1'b0, 1'b1, 16'h0777, 8'h00); resp_data = 8'h99; READY = 1'b0;
        tick; cif.req = 1'b0;
        tick; tick;
        checks++; if ({ALE, RDn} !== 2'b00) begin errors++; $display("FAIL rst_mid_in_tw: got ALE/RDn=%b expected 00", {ALE, RDn}); end
        RESETn = 1'b0;
        tick;
        checks++; if ({ALE, RDn, WRn, IO_Mn} !== 4'b0110 || AD !== 8'hFF) begin errors++; $display("FAIL rst_mid_strobes: got %b AD=%h expected 0110 FF", {ALE, RDn, WRn, IO_Mn}, AD); end
        checks++; if (cif.done !== 1'b0 || cif.req_ready !== 1'b1 || ADD !== 16'h0000 || cif.rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_state: got done=%b rr=%b ADD=%h rdata=%h expected 0 1 0000 00", cif.done, cif.req_ready, ADD, cif.rdata); end
        RESETn = 1'b1; READY = 1'b1;
        tick; tick;
        checks++; if (cif.done !== 1'b0 || RDn !== 1'b1) begin errors++; $display("FAIL rst_mid_no_done: got done=%b RDn=%b expected 0 1", cif.done, RDn); end
        $display("reset during TW: aborted");
    endtask

    task automatic test_timeout;
        int n_done = 0;
`ifdef WAIT_TIMEOUT_EN
        int rd_wait = 0;
        int done_at = 0;
        logic err_at = 1'b0;
        logic [7:0] rdata_at = 8'h00;
        request(1'b0, 1'b0, 16'h0900, 8'h00); resp_data = 8'h77; READY = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick;
            if (cyc == 1) cif.req = 1'b0;
            if (RDn === 1'b0 && cif.req_ready === 1'b0) rd_wait++;
            if (cif.done === 1'b1) begin
                n_done++;
                if (done_at == 0) begin done_at = cyc; err_at = cif.err; rdata_at = cif.rdata; end
            end
        end
        checks++; if (rd_wait != 17) begin errors++; $display("FAIL to_tw_count: got %0d expected 17 (T2 + 16 TW)", rd_wait - 1 + 1); end
        checks++; if (done_at != 20 || n_done != 1) begin errors++; $display("FAIL to_done: got at %0d n=%0d expected at 20 n=1", done_at, n_done); end
        checks++; if (err_at !== 1'b1 || rdata_at !== 8'h00) begin errors++; $display("FAIL to_err: got err=%b rdata=%h expected 1 00", err_at, rdata_at); end
        READY = 1'b1;
        $display("timeout: done at %0d err=%b", done_at, err_at);
`else
        request(1'b0, 1'b0, 16'h0900, 8'h00); resp_data = 8'h77; READY = 1'b0;
        for (int cyc = 1; cyc <= 102; cyc++) begin
            tick;
            if (cyc == 1) cif.req = 1'b0;
            if (cif.done === 1'b1 || cif.err === 1'b1) n_done++;
        end
        checks++; if ({ALE, RDn, cif.req_ready} !== 3'b000) begin errors++; $display("FAIL stuck_tw: got ALE/RDn/rr=%b expected 000", {ALE, RDn, cif.req_ready}); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL stuck_no_done: got %0d pulses expected 0", n_done); end
        RESETn = 1'b0; tick; RESETn = 1'b1; READY = 1'b1; tick;
        $display("no timeout: still waiting after 100 clocks");
`endif
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_wait_states;
        test_back_to_back;
        test_reset_mid;
        test_timeout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
